// File: rtl/ms_sched_pkg.sv
// rtl/ms_sched_pkg.sv - shared types and constants for the millisecond timer scheduler
package ms_sched_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_CNT_W = 16;

  // Width of the sweep index / channel select; never narrower than one bit.
  function automatic int sweep_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ms_prescaler.sv
// rtl/ms_prescaler.sv - divides the system clock down to a one-cycle 1 ms strobe
module ms_prescaler #(
  parameter int CLK_PER_MS = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic ms_tick
);

  localparam int PW = $clog2(CLK_PER_MS);
  localparam logic [PW-1:0] LAST = PW'(CLK_PER_MS - 1);

  logic [PW-1:0] cnt;

  // Count 0..CLK_PER_MS-1; the strobe is registered so it follows the wrap by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      ms_tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt     <= '0;
      ms_tick <= 1'b1;
    end else begin
      cnt     <= cnt + 1'b1;
      ms_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/ms_timer_scheduler.sv
// rtl/ms_timer_scheduler.sv - N-channel ms timers sharing one swept decrementer
module ms_timer_scheduler
  import ms_sched_pkg::*;
#(
  parameter int CLK_PER_MS = 100000,
  parameter int N_CH       = DEF_N_CH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_we,
  input  logic [sweep_idx_w(N_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]               cfg_period,
  input  logic                           cfg_periodic,
  input  logic [N_CH-1:0]                start,
  input  logic [N_CH-1:0]                stop,
  output logic [N_CH-1:0]                active,
  output logic [N_CH-1:0]                fire,
  output logic                           ms_tick
);

  localparam int CH_W = sweep_idx_w(N_CH);

  logic [CNT_W-1:0] period_q   [N_CH];
  logic             periodic_q [N_CH];
  logic [CNT_W-1:0] remain_q   [N_CH];
  ch_state_e        state_q    [N_CH];

  logic             sweep_busy;
  logic [CH_W-1:0]  sweep_idx;

  logic [CNT_W-1:0] cur_remain;
  logic [CNT_W-1:0] dec_remain;
  logic             cur_hit;

  ms_prescaler #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .ms_tick(ms_tick)
  );

  // Sweep sequencer: each ms tick walks the index across all channels, one per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_busy <= 1'b0;
      sweep_idx  <= '0;
    end else if (ms_tick) begin
      sweep_busy <= 1'b1;
      sweep_idx  <= '0;
    end else if (sweep_busy) begin
      if (sweep_idx == CH_W'(N_CH - 1)) begin
        sweep_busy <= 1'b0;
      end else begin
        sweep_idx <= sweep_idx + 1'b1;
      end
    end
  end

  // Single shared decrementer and expiry compare, fed by the channel in the sweep slot.
  always_comb begin
    cur_remain = remain_q[sweep_idx];
    dec_remain = cur_remain - CNT_W'(1);
    cur_hit    = (cur_remain == CNT_W'(1));
  end

  // Channel register file: config, start/stop (stop first) and the sweep update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire <= '0;
      for (int i = 0; i < N_CH; i++) begin
        period_q[i]   <= '0;
        periodic_q[i] <= 1'b0;
        remain_q[i]   <= '0;
        state_q[i]    <= CH_IDLE;
      end
    end else begin
      fire <= '0;
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_we && (cfg_ch == CH_W'(i))) begin
          period_q[i]   <= cfg_period;
          periodic_q[i] <= cfg_periodic;
        end
        if (stop[i]) begin
          state_q[i] <= CH_IDLE;
        end else if (start[i] && (period_q[i] != '0)) begin
          remain_q[i] <= period_q[i];
          state_q[i]  <= CH_RUN;
        end else if (sweep_busy && (sweep_idx == CH_W'(i)) && (state_q[i] == CH_RUN)) begin
          if (cur_hit) begin
            fire[i] <= 1'b1;
            // A periodic channel reprogrammed to 0 cannot reload, so it parks in IDLE.
            if (periodic_q[i] && (period_q[i] != '0)) begin
              remain_q[i] <= period_q[i];
            end else begin
              state_q[i] <= CH_IDLE;
            end
          end else begin
            remain_q[i] <= dec_remain;
          end
        end
      end
    end
  end

  // Running flags straight from channel state.
  always_comb begin
    active = '0;
    for (int i = 0; i < N_CH; i++) begin
      active[i] = (state_q[i] == CH_RUN);
    end
  end

endmodule

// File: doc/ms_timer_scheduler.md
# ms_timer_scheduler

Multi-channel millisecond timer scheduler for the game timebase. Generates a 1 ms strobe from the system clock and shares one down-counter datapath among N_CH software-style timers (Pacman step, ghost step, power-pellet, animation). Each channel is one-shot or periodic and raises a one-cycle `fire` pulse on expiry. Gameplay FSMs consume the pulses in place of free-running divided clocks.

## Interface
- `CLK_PER_MS`, default 100000: system clocks per millisecond; must be > N_CH+2.
- `N_CH`, default 4: number of timer channels.
- `CNT_W`, default 16: width of period and remaining-count registers.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cfg_we`  in  1  write `cfg_period`/`cfg_periodic` into channel `cfg_ch`.
- `cfg_ch`  in  $clog2(N_CH)  channel select for configuration.
- `cfg_period`  in  CNT_W  period in ms; 0 means channel cannot start.
- `cfg_periodic`  in  1  1 = reload on expiry; 0 = one-shot.
- `start`  in  N_CH  per-channel start/restart strobe.
- `stop`  in  N_CH  per-channel stop strobe.
- `active`  out  N_CH  channel is running.
- `fire`  out  N_CH  one-cycle expiry pulse.
- `ms_tick`  out  1  one-cycle 1 ms strobe.

## Operation
- Prescaler counts 0..CLK_PER_MS-1 and wraps; `ms_tick` is registered high for one cycle after each wrap.
- Per-channel registers: `period`, `periodic`, `remain`, state IDLE/RUN.
- Config write: updates `period`/`periodic` only; a running channel keeps its `remain` and uses the new period at next reload or start.
- Start: if `period`!=0, `remain`<=period, state RUN (restart when already running). If `period`==0, start is ignored.
- Stop: state IDLE, `remain` unchanged; no `fire`.
- Start and stop on the same channel in the same cycle: stop wins.
- Sweep: `ms_tick` launches a sweep with index 0..N_CH-1, one channel per cycle, through the single shared decrementer/compare. For a RUN channel: if `remain`==1, fire; a periodic channel reloads `remain`<=period, a one-shot goes IDLE. Otherwise `remain`<=remain-1. IDLE channels are skipped with no update.
- A start or stop on the channel currently in its sweep slot overrides the sweep result; no `fire` is produced for that channel in that cycle.
- `cfg_we` and `start` in the same cycle on the same channel: start uses the old period; the new period applies from the next reload.
- Arithmetic is unsigned CNT_W; `remain` never reaches 0 while RUN.

## Timing
- Reset values: prescaler 0, sweep idle, all `remain`/`period`/`periodic` 0, state IDLE, `active`=0, `fire`=0, `ms_tick`=0.
- The first `ms_tick` occurs CLK_PER_MS cycles after reset release.
- With `ms_tick` high in cycle T, channel k is evaluated in cycle T+1+k, and `fire[k]` is high in cycle T+2+k only.
- For a one-shot, `active[k]` falls in the same cycle that `fire[k]` rises.
- `start` in cycle S sets `active` in cycle S+1. The first fire follows the period-th subsequent `ms_tick`, so latency is (period-1, period] ms.
- A periodic channel fires exactly every period*CLK_PER_MS cycles, with no drift.
- Reset mid-sweep aborts the sweep and suppresses any pending `fire`.

## Structure
- Package `ms_sched_pkg`: channel state enum (IDLE, RUN), default N_CH/CNT_W constants, and the sweep-index width function.
- Sub-module `ms_prescaler`: clock-to-1 ms strobe counter with parameter CLK_PER_MS. The top level holds the channel register file, sweep sequencer, and shared decrementer.

## Test plan
All scenarios use CLK_PER_MS=10, N_CH=4.
- One-shot: ch0 period=3, start -> one `fire[0]` on the 3rd `ms_tick`, 2 cycles after it; `active[0]` falls in the same cycle; no further fires.
- Periodic: ch2 period=2, periodic -> `fire[2]` every 20 cycles for 10 periods, 4 cycles after the matching tick.
- Simultaneous expiry: all channels period=1 started together -> `fire[0..3]` in 4 consecutive cycles T+2..T+5.
- Conflicts, each checked separately:
  - start+stop same cycle -> IDLE.
  - Stop on the channel's sweep slot -> no `fire`.
  - start with period=0 -> `active` stays 0.
- Reconfig while running: ch1 period=5 running, `cfg_we` period=2 -> current expiry at 5 ms, later at every 2 ms.
- Reset: assert `rst_n` during a sweep with a fire pending -> `fire` never pulses, all outputs 0; the first `ms_tick` comes 10 cycles after release.
